// File: rtl/calc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// calc_cmd_sequencer
//
// Front-end for the calc unit. Takes one complete command (operand-1, opcode,
// operand-2) per valid/ready handshake and serialises it into calc's
// single-word validIn/dataIn pulse protocol. It then waits out calc's latency,
// samples calc's dataOut and returns the result on a valid/ready response
// channel. Only one command is in flight at a time.
//
// Parameters
//   GAP_CYCLES  : idle cycles after each word pulse (1..255)
//   RESULT_WAIT : extra cycles after the final gap before sampling (0..255)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   cmd_valid    command present
//   cmd_ready    block can accept a command (FSM idle)
//   cmd_op1      operand-1
//   cmd_opcode   0=ADD 1=MUL 2=SQUARE 3=INC, 4..7 reserved
//   cmd_op2      operand-2, ignored for unary opcodes
//   calc_valid   drives calc validIn, one-cycle pulse per word
//   calc_data    drives calc dataIn
//   calc_result  calc dataOut
//   rsp_valid    response present
//   rsp_ready    consumer accepts response
//   rsp_data     sampled calc result (0 for a reserved opcode)
//   rsp_err      command carried a reserved opcode
//   busy         FSM not idle (includes the response phase)
//   rsp_cnt      completed-response counter, wraps at 256
// -----------------------------------------------------------------------------
module calc_cmd_sequencer #(
    parameter int GAP_CYCLES  = 1,
    parameter int RESULT_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_op1,
    input  logic [2:0]  cmd_opcode,
    input  logic [15:0] cmd_op2,
    output logic        calc_valid,
    output logic [15:0] calc_data,
    input  logic [15:0] calc_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  rsp_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_OP1,
        S_GAP1,
        S_OPC,
        S_GAP2,
        S_OP2,
        S_GAP3,
        S_WAIT,
        S_RESP
    } state_t;

    // Down-counter reload values: a phase of N cycles loads N-1 and exits at 0.
    // WAIT_LOAD is never used when RESULT_WAIT is 0 (WAIT is skipped).
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] WAIT_LOAD = 8'(RESULT_WAIT - 1);

    // Opcodes 4..7 are reserved; 2 and 3 are unary (no operand-2 word).
    function automatic logic is_reserved(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_unary(input logic [2:0] op);
        return op[1];
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        calc_valid_q, calc_valid_d;
    logic [15:0] calc_data_q, calc_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rsp_cnt_q, rsp_cnt_d;

    // Command fields that are needed after the accept edge.
    logic [2:0]  opc_q;
    logic [15:0] op2_q;

    logic accept;
    logic go_result;

    assign accept = cmd_valid && (state_q == S_IDLE);

    // -------------------------------------------------------------------------
    // Command capture (data only, no reset needed)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            opc_q <= cmd_opcode;
            op2_q <= cmd_op2;
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            calc_valid_q <= 1'b0;
            calc_data_q  <= 16'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 16'd0;
            rsp_err_q    <= 1'b0;
            rsp_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            calc_valid_q <= calc_valid_d;
            calc_data_q  <= calc_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            rsp_cnt_q    <= rsp_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        calc_valid_d = 1'b0;
        calc_data_d  = calc_data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        rsp_cnt_d    = rsp_cnt_q;
        go_result    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (is_reserved(cmd_opcode)) begin
                        // Never touches calc: answer with an error response.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 16'd0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        // op1 goes out straight from the port on the accept edge.
                        state_d      = S_OP1;
                        calc_valid_d = 1'b1;
                        calc_data_d  = cmd_op1;
                    end
                end
            end

            S_OP1: begin
                state_d = S_GAP1;
                cnt_d   = GAP_LOAD;
            end

            S_GAP1: begin
                if (cnt_q == 8'd0) begin
                    state_d      = S_OPC;
                    calc_valid_d = 1'b1;
                    calc_data_d  = {13'd0, opc_q};
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_OPC: begin
                state_d = S_GAP2;
                cnt_d   = GAP_LOAD;
            end

            S_GAP2: begin
                if (cnt_q == 8'd0) begin
                    if (is_unary(opc_q)) begin
                        go_result = 1'b1;
                    end else begin
                        state_d      = S_OP2;
                        calc_valid_d = 1'b1;
                        calc_data_d  = op2_q;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_OP2: begin
                state_d = S_GAP3;
                cnt_d   = GAP_LOAD;
            end

            S_GAP3: begin
                if (cnt_q == 8'd0) begin
                    go_result = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = calc_result;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_cnt_d   = rsp_cnt_q + 8'd1;
                    calc_data_d = 16'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Last gap finished: either wait for calc or, with no extra wait,
        // sample its result on this same edge.
        if (go_result) begin
            if (RESULT_WAIT == 0) begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = calc_result;
                rsp_err_d   = 1'b0;
            end else begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LOAD;
            end
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign calc_valid = calc_valid_q;
    assign calc_data  = calc_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_cnt    = rsp_cnt_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_cmd_sequencer
//
// Directed, table-driven bench for calc_cmd_sequencer at default parameters.
// A small behavioural calc model consumes the word pulses and produces
// calc_result; expected responses, latencies and word streams come from the
// vector table. Hand-written sequences cover backpressure, counter wrap and
// asynchronous reset mid-command.
// -----------------------------------------------------------------------------
module tb_calc_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_op1;
    logic [2:0]  cmd_opcode;
    logic [15:0] cmd_op2;
    logic        calc_valid;
    logic [15:0] calc_data;
    logic [15:0] calc_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  rsp_cnt;

    always #5 clk = ~clk;

    calc_cmd_sequencer #(
        .GAP_CYCLES  (1),
        .RESULT_WAIT (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op1     (cmd_op1),
        .cmd_opcode  (cmd_opcode),
        .cmd_op2     (cmd_op2),
        .calc_valid  (calc_valid),
        .calc_data   (calc_data),
        .calc_result (calc_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .rsp_cnt     (rsp_cnt)
    );

    // Behavioural calc: word 0 = op1, word 1 = opcode, word 2 = op2 (binary).
    logic [15:0] m_op1;
    logic [2:0]  m_opc;
    logic [1:0]  m_idx;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idx       <= 2'd0;
            m_op1       <= 16'd0;
            m_opc       <= 3'd0;
            calc_result <= 16'd0;
        end else if (calc_valid) begin
            case (m_idx)
                2'd0: begin
                    m_op1 <= calc_data;
                    m_idx <= 2'd1;
                end
                2'd1: begin
                    m_opc <= calc_data[2:0];
                    if (calc_data[1]) begin
                        calc_result <= calc_data[0] ? 16'(m_op1 + 16'd1) : 16'(m_op1 * m_op1);
                        m_idx       <= 2'd0;
                    end else begin
                        m_idx <= 2'd2;
                    end
                end
                default: begin
                    calc_result <= m_opc[0] ? 16'(m_op1 * calc_data) : 16'(m_op1 + calc_data);
                    m_idx       <= 2'd0;
                end
            endcase
        end
    end

    typedef struct {
        logic [15:0] op1;
        logic [2:0]  opc;
        logic [15:0] op2;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_np;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
    } vec_t;

    vec_t vecs [8];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_cnt;

    int          got_np;
    int          got_lat;
    logic [15:0] got_w [4];
    int          got_c [4];
    bit          hold_bad;
    bit          busy_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present a command and wait (bounded) for it to be accepted.
    task automatic drive_cmd(input logic [15:0] a, input logic [2:0] o, input logic [15:0] b);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op1    = a;
        cmd_opcode = o;
        cmd_op2    = b;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        // Inputs only have to be stable at the accept edge.
        cmd_valid  = 1'b0;
        cmd_op1    = 16'($urandom);
        cmd_opcode = 3'($urandom);
        cmd_op2    = 16'($urandom);
    endtask

    // Watch cycles 1.. after acceptance until rsp_valid rises (bounded).
    task automatic collect();
        logic [15:0] last;
        int k;
        k        = 0;
        last     = 16'd0;
        got_np   = 0;
        got_lat  = -1;
        hold_bad = 1'b0;
        busy_bad = 1'b0;
        while (k < 40 && got_lat < 0) begin
            @(negedge clk);
            k++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) busy_bad = 1'b1;
            if (calc_valid === 1'b1) begin
                if (got_np < 4) begin
                    got_w[got_np] = calc_data;
                    got_c[got_np] = k;
                end
                got_np++;
                last = calc_data;
            end else if (got_np > 0 && calc_data !== last) begin
                hold_bad = 1'b1;
            end
            if (rsp_valid === 1'b1) got_lat = k;
        end
    endtask

    // Hold off the response for 'hold' cycles, then accept it.
    task automatic finish_rsp(input int hold, input logic [15:0] d, input logic e);
        bit stable_bad;
        stable_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_err !== e ||
                cmd_ready !== 1'b0 || calc_valid !== 1'b0)
                stable_bad = 1'b1;
        end
        if (hold > 0) chk("rsp_hold_stable", 32'(stable_bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_cnt   = exp_cnt + 8'd1;
        @(negedge clk);
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("idle_calc_data", 32'(calc_data), 32'd0);
        chk("rsp_cnt", 32'(rsp_cnt), 32'(exp_cnt));
    endtask

    task automatic run_vec(input int i, input int hold);
        logic [15:0] ew [3];
        vec_t v;
        v     = vecs[i];
        ew[0] = v.w0;
        ew[1] = v.w1;
        ew[2] = v.w2;
        drive_cmd(v.op1, v.opc, v.op2);
        collect();
        chk($sformatf("v%0d_latency", i), 32'(got_lat), 32'(v.exp_lat));
        chk($sformatf("v%0d_pulses", i), 32'(got_np), 32'(v.exp_np));
        chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(v.exp_data));
        chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(v.exp_err));
        chk($sformatf("v%0d_busy", i), 32'(busy_bad), 32'd0);
        chk($sformatf("v%0d_data_hold", i), 32'(hold_bad), 32'd0);
        for (int j = 0; j < v.exp_np && j < got_np && j < 3; j++) begin
            chk($sformatf("v%0d_word%0d", i, j), 32'(got_w[j]), 32'(ew[j]));
            chk($sformatf("v%0d_wcyc%0d", i, j), 32'(got_c[j]), 32'(1 + 2 * j));
        end
        finish_rsp(hold, v.exp_data, v.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             op1       opc    op2       data      err   lat np  w0        w1     w2
        vecs[0] = '{16'd2,     3'd2, 16'd0,     16'd4,     1'b0, 6, 2, 16'd2,     16'd2, 16'd0};
        vecs[1] = '{16'd3,     3'd1, 16'd5,     16'd15,    1'b0, 8, 3, 16'd3,     16'd1, 16'd5};
        vecs[2] = '{16'd300,   3'd1, 16'd300,   16'd24464, 1'b0, 8, 3, 16'd300,   16'd1, 16'd300};
        vecs[3] = '{16'd7,     3'd0, 16'd9,     16'd16,    1'b0, 8, 3, 16'd7,     16'd0, 16'd9};
        vecs[4] = '{16'd41,    3'd3, 16'd999,   16'd42,    1'b0, 6, 2, 16'd41,    16'd3, 16'd0};
        vecs[5] = '{16'd1234,  3'd5, 16'd777,   16'd0,     1'b1, 1, 0, 16'd0,     16'd0, 16'd0};
        vecs[6] = '{16'hFFFF,  3'd7, 16'hFFFF,  16'd0,     1'b1, 1, 0, 16'd0,     16'd0, 16'd0};
        vecs[7] = '{16'hFFFF,  3'd0, 16'd2,     16'd1,     1'b0, 8, 3, 16'hFFFF,  16'd0, 16'd2};

        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op1    = 16'd0;
        cmd_opcode = 3'd0;
        cmd_op2    = 16'd0;
        rsp_ready  = 1'b0;
        exp_cnt    = 8'd0;

        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_calc_valid", 32'(calc_valid), 32'd0);
        chk("rst_calc_data", 32'(calc_data), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_cnt", 32'(rsp_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table of directed commands.
        for (int i = 0; i < 8; i++) run_vec(i, 0);

        // Backpressure on ADD 7+9 with a SQUARE 3 waiting on cmd_valid.
        drive_cmd(16'd7, 3'd0, 16'd9);
        collect();
        chk("bp_rsp_data", 32'(rsp_data), 32'd16);
        chk("bp_latency", 32'(got_lat), 32'd8);
        cmd_valid  = 1'b1;
        cmd_op1    = 16'd3;
        cmd_opcode = 3'd2;
        cmd_op2    = 16'd0;
        finish_rsp(3, 16'd16, 1'b0);
        // cmd_valid is still high: the pending command goes in on this edge.
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        collect();
        chk("bp_pending_latency", 32'(got_lat), 32'd6);
        chk("bp_pending_pulses", 32'(got_np), 32'd2);
        chk("bp_pending_data", 32'(rsp_data), 32'd9);
        finish_rsp(0, 16'd9, 1'b0);

        // Fill up to 255 completed responses, then one more wraps to 0.
        while (exp_cnt != 8'd255) run_vec(5, 0);
        chk("cnt_at_255", 32'(rsp_cnt), 32'd255);
        run_vec(6, 0);
        chk("cnt_wrapped", 32'(rsp_cnt), 32'd0);

        // Asynchronous reset during the OP2 pulse of MUL 3*5.
        begin
            int  k;
            bit  stray;
            drive_cmd(16'd3, 3'd1, 16'd5);
            k = 0;
            while (k < 5) begin
                @(negedge clk);
                k++;
            end
            chk("abort_op2_valid", 32'(calc_valid), 32'd1);
            chk("abort_op2_data", 32'(calc_data), 32'd5);
            #2;
            rst = 1'b0;
            #1;
            chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_calc_valid", 32'(calc_valid), 32'd0);
            chk("abort_calc_data", 32'(calc_data), 32'd0);
            chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("abort_rsp_cnt", 32'(rsp_cnt), 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst     = 1'b1;
            exp_cnt = 8'd0;
            stray   = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b0 || calc_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
            end
            chk("abort_no_response", 32'(stray), 32'd0);
        end
        run_vec(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
